gauss_out_stage: RTL and testbench

- Downstream stage of the 3x3 Gaussian kernel (weights 1-2-1/2-4-2/1-2-1; weight sum 16).
- Consumes the kernel's raw 15-bit weighted-sum stream and normalises it to 8-bit pixels with rounding and saturation.
- Discards border/warm-up samples, tags the kept pixels with line/frame markers, and buffers them into a valid/ready output with a 4-deep FIFO.

---
 rtl/gauss_pkg.sv | 24 ++
 rtl/gauss_out_stage_if.sv | 27 ++
 rtl/gauss_out_fifo.sv | 57 +++++
 rtl/gauss_out_stage.sv | 121 ++++++++++++
 tb/tb_gauss_out_stage.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gauss_pkg.sv
// Shared constants, the output word layout and the normalise/saturate helper
// for the Gaussian kernel output stage.
package gauss_pkg;

  localparam int KERNEL_SHIFT = 4;
  localparam int ROUND_C      = 8;
  localparam int PIX_MAX      = 255;

  typedef struct packed {
    logic [7:0] pix;
    logic       sol;
    logic       eol;
    logic       sof;
    logic       eof;
  } pix_entry_t;

  // Widening to 32 bits keeps sum + ROUND_C exact for any SUM_W up to 31
  function automatic logic [7:0] norm_sat(input logic [31:0] sum);
    logic [31:0] t;
    t = (sum + 32'(ROUND_C)) >> KERNEL_SHIFT;
    return (t > 32'(PIX_MAX)) ? 8'(PIX_MAX) : t[7:0];
  endfunction

endpackage

// File: rtl/gauss_out_stage_if.sv
// Streaming bus of the output stage: raw kernel sums in, tagged pixels out
// with a valid/ready handshake.
interface gauss_out_stage_if #(
  parameter int SUM_W = 15
);

  logic             in_valid;
  logic [SUM_W-1:0] in_sum;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_pix;
  logic             out_sol;
  logic             out_eol;
  logic             out_sof;
  logic             out_eof;

  modport master (
    output in_valid, in_sum, out_ready,
    input  out_valid, out_pix, out_sol, out_eol, out_sof, out_eof
  );

  modport slave (
    input  in_valid, in_sum, out_ready,
    output out_valid, out_pix, out_sol, out_eol, out_sof, out_eof
  );

endinterface

// File: rtl/gauss_out_fifo.sv
// First-word-fall-through FIFO; a write into a full FIFO is accepted only
// when a read frees a slot in the same cycle.
module gauss_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_rd;
  logic             do_wr;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero while empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gauss_out_stage.sv
// Normalises the 3x3 Gaussian weighted sum to 8-bit pixels, drops border
// samples, tags line/frame boundaries and buffers the result for downstream.
module gauss_out_stage
  import gauss_pkg::*;
#(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int SUM_W      = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sync_clr,
  gauss_out_stage_if.slave   bus,
  output logic               overflow,
  output logic               frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] cur_row;
  logic             last_col;
  logic             last_row;
  logic             keep;
  pix_entry_t       new_entry;

  logic             s1_valid;
  pix_entry_t       s1_entry;

  logic             fifo_wr;
  logic             fifo_rd;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  pix_entry_t       head;

  // A sample arriving with sync_clr is placed at (0,0), so it is never kept
  always_comb begin
    cur_col           = sync_clr ? '0 : col;
    cur_row           = sync_clr ? '0 : row;
    last_col          = (cur_col == COL_W'(IMG_W - 1));
    last_row          = (cur_row == ROW_W'(IMG_H - 1));
    keep              = bus.in_valid && (cur_col >= COL_W'(2)) && (cur_row >= ROW_W'(2));
    new_entry.pix     = norm_sat(32'(bus.in_sum));
    new_entry.sol     = (cur_col == COL_W'(2));
    new_entry.eol     = last_col;
    new_entry.sof     = (cur_row == ROW_W'(2)) && (cur_col == COL_W'(2));
    new_entry.eof     = last_row && last_col;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= bus.in_valid && !sync_clr && last_col && last_row;
      if (sync_clr) begin
        col <= '0;
        row <= '0;
      end else if (bus.in_valid) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_entry <= '0;
    end else begin
      s1_valid <= keep;
      s1_entry <= new_entry;
    end
  end

  // Full FIFO still takes the word when the head is read in the same cycle
  assign fifo_rd = bus.out_ready && (fifo_count != '0);
  assign fifo_wr = s1_valid && (!fifo_full || fifo_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (s1_valid && !fifo_wr) begin
      overflow <= 1'b1;
    end
  end

  gauss_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pix_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (s1_entry),
    .rd_en   (fifo_rd),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_pix   = head.pix;
  assign bus.out_sol   = head.sol;
  assign bus.out_eol   = head.eol;
  assign bus.out_sof   = head.sof;
  assign bus.out_eof   = head.eof;

endmodule

// File: tb/tb_gauss_out_stage.sv
// Randomised bench for gauss_out_stage on a 6x5 image, checked every cycle
// against a position/queue reference model.
module tb_gauss_out_stage;

  localparam int W     = 6;
  localparam int H     = 5;
  localparam int SUM_W = 15;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sync_clr = 1'b0;
  logic overflow;
  logic frame_done;

  always #5 clk = ~clk;

  gauss_out_stage_if #(.SUM_W(SUM_W)) bus ();

  gauss_out_stage #(
    .IMG_W      (W),
    .IMG_H      (H),
    .SUM_W      (SUM_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sync_clr   (sync_clr),
    .bus        (bus),
    .overflow   (overflow),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: linear sample index, pending kept word and output queue
  int          m_idx;
  logic [11:0] m_q[$];
  logic        m_pend_v;
  logic [11:0] m_pend;
  logic        m_ovf;
  logic        m_fd;

  logic [11:0] got[$];
  logic [11:0] got_ref[$];
  logic [11:0] kept_log[$];
  int          fd_seen;
  int          sums_a[30];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] refEntry(input int col, input int row, input int sum);
    int p;
    p = (sum + 8) / 16;
    if (p > 255) p = 255;
    return {8'(p), col == 2, col == W - 1, (row == 2) && (col == 2), (row == H - 1) && (col == W - 1)};
  endfunction

  task automatic modelReset();
    m_idx    = 0;
    m_q.delete();
    m_pend_v = 1'b0;
    m_pend   = '0;
    m_ovf    = 1'b0;
    m_fd     = 1'b0;
  endtask

  task automatic applyStimulus(input logic valid, input int sum, input logic clr, input logic ready);
    int col;
    int row;
    bus.in_valid  = valid;
    bus.in_sum    = SUM_W'(sum);
    sync_clr      = clr;
    bus.out_ready = ready;
    if (ready && bus.out_valid)
      got.push_back({bus.out_pix, bus.out_sol, bus.out_eol, bus.out_sof, bus.out_eof});
    @(posedge clk);
    if (ready && m_q.size() > 0) void'(m_q.pop_front());
    if (m_pend_v) begin
      if (m_q.size() == DEPTH) m_ovf = 1'b1;
      else m_q.push_back(m_pend);
    end
    m_fd     = valid && !clr && (m_idx == W * H - 1);
    m_pend_v = 1'b0;
    col      = clr ? 0 : m_idx % W;
    row      = clr ? 0 : m_idx / W;
    if (valid && col >= 2 && row >= 2) begin
      m_pend_v = 1'b1;
      m_pend   = refEntry(col, row, sum);
      kept_log.push_back(m_pend);
    end
    if (clr) m_idx = 0;
    else if (valid) m_idx = (m_idx + 1) % (W * H);
    #1;
    checkOutput("out_valid", bus.out_valid, m_q.size() > 0);
    if (m_q.size() > 0)
      checkOutput("head_word", {bus.out_pix, bus.out_sol, bus.out_eol, bus.out_sof, bus.out_eof}, m_q[0]);
    checkOutput("overflow", overflow, m_ovf);
    checkOutput("frame_done", frame_done, m_fd);
    if (frame_done) fd_seen++;
  endtask

  task automatic idle(input int n, input logic ready);
    repeat (n) applyStimulus(1'b0, 0, 1'b0, ready);
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_valid"}, bus.out_valid, 0);
    checkOutput({tag, "_pix"}, bus.out_pix, 0);
    checkOutput({tag, "_tags"}, {bus.out_sol, bus.out_eol, bus.out_sof, bus.out_eof}, 0);
    checkOutput({tag, "_overflow"}, overflow, 0);
    checkOutput({tag, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    int          norm_in[6];
    logic [7:0]  norm_exp[6];
    logic [3:0]  tag_exp;
    int          k;
    int          s;
    bit          hit;

    norm_in  = '{0, 7, 8, 4080, 4088, 32767};
    norm_exp = '{8'd0, 8'd0, 8'd1, 8'd255, 8'd255, 8'd255};
    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.out_ready = 1'b0;
    modelReset();

    #12;
    checkZeroOutputs("init_reset");
    @(negedge clk);
    rst = 1'b0;

    // Full frame with no gaps: border removal and tags
    got.delete();
    fd_seen = 0;
    for (int i = 0; i < 30; i++) begin
      sums_a[i] = $urandom_range(0, 32767);
      applyStimulus(1'b1, sums_a[i], 1'b0, 1'b1);
    end
    idle(4, 1'b1);
    checkOutput("frame_out_count", got.size(), 12);
    checkOutput("frame_done_pulses", fd_seen, 1);
    for (int i = 0; i < 12 && i < got.size(); i++) begin
      tag_exp = {i % 4 == 0, i % 4 == 3, i == 0, i == 11};
      checkOutput($sformatf("tags_out%0d", i + 1), got[i][3:0], tag_exp);
    end
    got_ref = got;

    // Rounding and saturation corners on the first six kept positions
    got.delete();
    k = 0;
    for (int i = 0; i < 30; i++) begin
      s = $urandom_range(0, 32767);
      if (i % W >= 2 && i / W >= 2 && k < 6) begin
        s = norm_in[k];
        k++;
      end
      applyStimulus(1'b1, s, 1'b0, 1'b1);
    end
    idle(4, 1'b1);
    checkOutput("norm_out_count", got.size(), 12);
    for (int i = 0; i < 6 && i < got.size(); i++)
      checkOutput($sformatf("norm_%0d", norm_in[i]), got[i][11:4], norm_exp[i]);

    // Fill the FIFO, then land the next write on a read cycle
    hit = 0;
    for (int i = 0; i < 60; i++) begin
      if (m_pend_v && m_q.size() == DEPTH) begin
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        hit = 1;
        break;
      end
      applyStimulus(1'b1, $urandom_range(0, 32767), 1'b0, 1'b0);
    end
    checkOutput("collision_reached", hit, 1);
    checkOutput("collision_count", 32'(dut.u_fifo.count), 4);
    checkOutput("collision_overflow", overflow, 0);
    idle(8, 1'b1);

    // sync_clr mid-line, then the first frame replayed with one-cycle gaps
    applyStimulus(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, $urandom_range(0, 32767), 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 1'b1, 1'b1);
    got.delete();
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, sums_a[i], 1'b0, 1'b1);
      applyStimulus(1'b0, $urandom_range(0, 32767), 1'b0, 1'b1);
    end
    idle(4, 1'b1);
    checkOutput("gap_out_count", got.size(), got_ref.size());
    for (int i = 0; i < got.size() && i < got_ref.size(); i++)
      checkOutput($sformatf("gap_out%0d", i + 1), got[i], got_ref[i]);

    // Backpressure: six kept samples against a stalled sink
    applyStimulus(1'b0, 0, 1'b1, 1'b1);
    idle(2, 1'b1);
    kept_log.delete();
    got.delete();
    for (int i = 0; i < 60 && kept_log.size() < 6; i++)
      applyStimulus(1'b1, $urandom_range(0, 32767), 1'b0, 1'b0);
    idle(2, 1'b0);
    checkOutput("bp_overflow", overflow, 1);
    checkOutput("bp_held", bus.out_valid, 1);
    idle(8, 1'b1);
    checkOutput("bp_drain_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      checkOutput($sformatf("bp_order%0d", i), got[i], kept_log[i]);
    checkOutput("bp_empty_after", bus.out_valid, 0);

    // Reset mid-stream with two words buffered
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, $urandom_range(0, 32767), 1'b0, 1'b0);
    idle(2, 1'b0);
    checkOutput("pre_reset_count", 32'(dut.u_fifo.count), 2);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkZeroOutputs("mid_reset");
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("reset_hold_valid", bus.out_valid, 0);
    rst = 1'b0;
    got.delete();
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, $urandom_range(0, 32767), 1'b0, 1'b1);
    idle(4, 1'b1);
    checkOutput("post_reset_out_count", got.size(), 12);

    // Random traffic with random sink stalls and occasional clears
    for (int i = 0; i < 400; i++) begin
      logic v;
      logic r;
      logic c;
      v = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 9) < 7);
      c = !v && ($urandom_range(0, 19) == 0);
      applyStimulus(v, $urandom_range(0, 32767), c, r);
    end
    idle(8, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
